// File: rtl/keypad_booth_mult.sv
// keypad_booth_mult: keypad operand entry sequencer with iterative Booth multiplier.
// Define RADIX4_EN for radix-4 recoding (OP_W/2 multiply cycles instead of OP_W).
module keypad_booth_mult #(
  parameter int OP_W = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_pressed,
  input  logic [3:0]        key_value,
  input  logic              is_sign_key,
  output logic [2*OP_W-1:0] product,
  output logic              product_valid,
  output logic              busy,
  output logic [1:0]        state_o,
  output logic [2*OP_W-1:0] disp_value,
  output logic              disp_neg,
  output logic              entry_err
);
  localparam logic [1:0] ENTRY_A = 2'b00, ENTRY_B = 2'b01, MULT = 2'b10, DONE = 2'b11;
  localparam int AW = 2*OP_W+2;
  localparam int CW = $clog2(MAX_DIGITS+1);
`ifdef RADIX4_EN
  localparam int STEPS = OP_W/2;
`else
  localparam int STEPS = OP_W;
`endif
  localparam int SW = $clog2(STEPS+1);
  localparam int XW = OP_W+5;
  logic [1:0] state_q, state_d;
  logic kp_q;
  logic [OP_W-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d, mq_q, mq_d, mq_nx;
  logic neg_a_q, neg_a_d, neg_b_q, neg_b_d, qm1_q, qm1_d, qm1_nx;
  logic [CW-1:0] cnt_q, cnt_d, cur_cnt;
  logic signed [AW-1:0] acc_q, acc_d, a_sh, addend, acc_sum, acc_nx;
  logic [SW-1:0] step_q, step_d;
  logic [2*OP_W-1:0] prod_q, prod_d, disp_q, disp_d;
  logic pv_q, pv_d, err_q, err_d, dneg_q, dneg_d;
  logic ev, sgn, dig, ent, clr, in_a, ok, last, p_neg;
  logic [OP_W-1:0] cur_mag, a_val, b_val;
  logic [XW-1:0] cand;
  assign ev = key_pressed & ~kp_q;
  assign sgn = ev & is_sign_key;
  assign dig = ev & ~is_sign_key & (key_value <= 4'd9);
  assign ent = ev & ~is_sign_key & (key_value == 4'hE);
  assign clr = ev & ~is_sign_key & (key_value == 4'hF);
  assign in_a = state_q == ENTRY_A;
  assign cur_mag = state_q == DONE ? '0 : in_a ? mag_a_q : mag_b_q;
  assign cur_cnt = state_q == DONE ? '0 : cnt_q;
  assign cand = XW'(cur_mag) * XW'(10) + XW'(key_value);
  assign ok = cand <= XW'((1 << (OP_W-1)) - 1) && cur_cnt < CW'(MAX_DIGITS);
  assign a_val = neg_a_q ? -mag_a_q : mag_a_q;
  assign b_val = neg_b_q ? -mag_b_q : mag_b_q;
  assign a_sh = {{2{a_val[OP_W-1]}}, a_val, {OP_W{1'b0}}};
  assign last = step_q == SW'(STEPS-1);
  assign acc_sum = acc_q + addend;
`ifdef RADIX4_EN
  logic [2:0] trip;
  assign trip = {mq_q[1:0], qm1_q};
  assign addend = trip == 3'b011 ? a_sh <<< 1 : trip == 3'b100 ? -(a_sh <<< 1) :
                  (trip == 3'b001 || trip == 3'b010) ? a_sh :
                  (trip == 3'b101 || trip == 3'b110) ? -a_sh : '0;
  assign acc_nx = acc_sum >>> 2;
  assign mq_nx = {{2{mq_q[OP_W-1]}}, mq_q[OP_W-1:2]};
  assign qm1_nx = mq_q[1];
`else
  assign addend = {mq_q[0], qm1_q} == 2'b01 ? a_sh : {mq_q[0], qm1_q} == 2'b10 ? -a_sh : '0;
  assign acc_nx = acc_sum >>> 1;
  assign mq_nx = {mq_q[OP_W-1], mq_q[OP_W-1:1]};
  assign qm1_nx = mq_q[0];
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ENTRY_A;
      kp_q <= 1'b1;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      mq_q <= '0;
      qm1_q <= 1'b0;
      step_q <= '0;
      prod_q <= '0;
      pv_q <= 1'b0;
      err_q <= 1'b0;
      disp_q <= '0;
      dneg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kp_q <= key_pressed;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mq_q <= mq_d;
      qm1_q <= qm1_d;
      step_q <= step_d;
      prod_q <= prod_d;
      pv_q <= pv_d;
      err_q <= err_d;
      disp_q <= disp_d;
      dneg_q <= dneg_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ENTRY_A: state_d = ent ? ENTRY_B : ENTRY_A;
      ENTRY_B: state_d = ent ? MULT : ENTRY_B;
      MULT:    state_d = last ? DONE : MULT;
      default: state_d = (dig & ok) | clr ? ENTRY_A : DONE;
    endcase
  end
  always_comb begin
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    mq_d = mq_q;
    qm1_d = qm1_q;
    step_d = step_q;
    prod_d = prod_q;
    pv_d = 1'b0;
    err_d = dig & ~ok & (state_q != MULT);
    case (state_q)
      MULT: begin
        acc_d = acc_nx;
        mq_d = mq_nx;
        qm1_d = qm1_nx;
        step_d = step_q + SW'(1);
        prod_d = last ? acc_nx[2*OP_W-1:0] : prod_q;
        pv_d = last;
      end
      DONE: begin
        if (dig && ok) begin
          mag_a_d = cand[OP_W-1:0];
          cnt_d = CW'(1);
        end
        if ((dig && ok) || clr) begin
          mag_a_d = clr ? '0 : cand[OP_W-1:0];
          neg_a_d = 1'b0;
          mag_b_d = '0;
          neg_b_d = 1'b0;
          cnt_d = clr ? '0 : CW'(1);
        end
      end
      default: begin
        if (dig && ok) begin
          mag_a_d = in_a ? cand[OP_W-1:0] : mag_a_q;
          mag_b_d = in_a ? mag_b_q : cand[OP_W-1:0];
          cnt_d = cnt_q + CW'(1);
        end
        if (sgn) begin
          neg_a_d = in_a ? ~neg_a_q : neg_a_q;
          neg_b_d = in_a ? neg_b_q : ~neg_b_q;
        end
        if (clr || (ent && in_a)) begin
          mag_a_d = clr && in_a ? '0 : mag_a_q;
          neg_a_d = clr && in_a ? 1'b0 : neg_a_q;
          mag_b_d = '0;
          neg_b_d = 1'b0;
          cnt_d = '0;
        end
        if (ent && !in_a) begin
          acc_d = '0;
          mq_d = b_val;
          qm1_d = 1'b0;
          step_d = '0;
        end
      end
    endcase
  end
  // Display tracks the operand being edited, or the product once done; -0 shows as +0.
  assign p_neg = prod_q[2*OP_W-1];
  always_comb begin
    disp_d = state_q == DONE ? (p_neg ? -prod_q : prod_q) :
             in_a ? {{OP_W{1'b0}}, mag_a_q} : {{OP_W{1'b0}}, mag_b_q};
    dneg_d = state_q == DONE ? p_neg : in_a ? neg_a_q & |mag_a_q : neg_b_q & |mag_b_q;
  end
  assign product = prod_q;
  assign product_valid = pv_q;
  assign busy = state_q == MULT;
  assign state_o = state_q;
  assign disp_value = disp_q;
  assign disp_neg = dneg_q;
  assign entry_err = err_q;
endmodule
